// File: rtl/param_seq_detector_pkg.sv
// Shared types for the programmable serial pattern detector.
// Holds the FSM state encoding and the pattern-length legality check.
package param_seq_detector_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      UNCFG = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2
   } state_t;

   // A pattern length is usable only if it selects at least one stored symbol.
   function automatic logic len_legal(input int len, input int max_len);
      return (len >= 1) && (len <= max_len);
   endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Combinational compare of the newest len symbols of the history window
// against the loaded pattern; symbols at or above len are don't-care.
module seq_window_cmp #(
   parameter int SYM_W   = 1,
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic [MAX_LEN*SYM_W-1:0] hist,
   input  logic [MAX_LEN*SYM_W-1:0] pattern,
   input  logic [LEN_W-1:0]         len,
   output logic                     match
);

   always_comb begin
      match = 1'b1;
      for (int k = 0; k < MAX_LEN; k++) begin
         if ((k < int'(len)) &&
             (hist[k*SYM_W +: SYM_W] != pattern[k*SYM_W +: SYM_W])) begin
            match = 1'b0;
         end
      end
   end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered detect pulse, saturating match counter and config-error pulse.
module param_seq_detector
   import param_seq_detector_pkg::*;
#(
   parameter int SYM_W   = 1,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         in_valid,
   input  logic [SYM_W-1:0]             in_sym,
   input  logic                         cfg_load,
   input  logic [MAX_LEN*SYM_W-1:0]     cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   output logic                         detected,
   output logic [CNT_W-1:0]             match_count,
   output logic                         cfg_err
);

   localparam int LEN_W  = $clog2(MAX_LEN+1);
   localparam int HIST_W = MAX_LEN*SYM_W;

   state_t              state;
   logic [HIST_W-1:0]   pattern;
   logic [HIST_W-1:0]   hist;
   logic [HIST_W-1:0]   hist_shift;
   logic [LEN_W-1:0]    len;
   logic [LEN_W-1:0]    fill;
   logic [LEN_W-1:0]    fill_inc;
   logic                overlap;
   logic                accept;
   logic                win_match;
   logic                match;
   logic                cfg_legal;

   // Matching is judged on the window as it will look after this symbol shifts in.
   assign hist_shift = {hist[HIST_W-SYM_W-1:0], in_sym};
   assign fill_inc   = (fill >= len) ? len : fill + LEN_W'(1);
   assign cfg_legal  = len_legal(int'(cfg_len), MAX_LEN);
   assign accept     = en && in_valid && (state != UNCFG) && !cfg_load;
   assign match      = accept && win_match && (fill_inc == len);

   seq_window_cmp #(
      .SYM_W   (SYM_W),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_cmp (
      .hist    (hist_shift),
      .pattern (pattern),
      .len     (len),
      .match   (win_match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= UNCFG;
         pattern     <= '0;
         len         <= '0;
         overlap     <= 1'b0;
         hist        <= '0;
         fill        <= '0;
         detected    <= 1'b0;
         match_count <= '0;
         cfg_err     <= 1'b0;
      end else begin
         detected <= 1'b0;
         cfg_err  <= 1'b0;
         // Config path is deliberately not gated by en.
         if (cfg_load) begin
            if (cfg_legal) begin
               pattern     <= cfg_pattern;
               len         <= cfg_len;
               overlap     <= cfg_overlap;
               hist        <= '0;
               fill        <= '0;
               match_count <= '0;
               state       <= FILL;
            end else begin
               cfg_err <= 1'b1;
            end
         end else if (accept) begin
            hist <= hist_shift;
            if (match) begin
               detected <= 1'b1;
               if (match_count != '1) begin
                  match_count <= match_count + CNT_W'(1);
               end
               if (!overlap) begin
                  fill  <= '0;
                  state <= FILL;
               end else begin
                  fill  <= fill_inc;
                  state <= RUN;
               end
            end else begin
               fill <= fill_inc;
               if (fill_inc == len) begin
                  state <= RUN;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: a default instance plus a
// CNT_W=2 instance sharing all inputs for the counter saturation case.
module tb_param_seq_detector;
   import param_seq_detector_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        in_valid;
   logic [0:0]  in_sym;
   logic        cfg_load;
   logic [7:0]  cfg_pattern;
   logic [3:0]  cfg_len;
   logic        cfg_overlap;
   logic        detected;
   logic [15:0] match_count;
   logic        cfg_err;
   logic        detected2;
   logic [1:0]  match_count2;
   logic        cfg_err2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   param_seq_detector #(.SYM_W(1), .MAX_LEN(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sym(in_sym),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .detected(detected),
      .match_count(match_count), .cfg_err(cfg_err)
   );

   param_seq_detector #(.SYM_W(1), .MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_sym(in_sym),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .detected(detected2),
      .match_count(match_count2), .cfg_err(cfg_err2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A symbol is always offered during loads so the discard rule is exercised.
   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
      cfg_load    = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      in_valid    = 1'b1;
      in_sym      = 1'b1;
      tick();
      cfg_load = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic push_chk(input string tag, input logic sym, input logic exp_det);
      in_valid = 1'b1;
      in_sym   = sym;
      tick();
      in_valid = 1'b0;
      chk(tag, detected, exp_det);
   endtask

   // Streams n symbols MSB-first, checking the detect pulse after each accept.
   task automatic run_stream(input string tag, input logic [15:0] syms,
                             input logic [15:0] exps, input int n);
      for (int i = 0; i < n; i++) begin
         push_chk($sformatf("%s_sym%0d", tag, i+1), syms[n-1-i], exps[n-1-i]);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_sym = 1'b0;
      cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      tick();
      tick();
      chk("rst_detected", detected, 0);
      chk("rst_count", match_count, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_state", 32'(dut.state), 32'(UNCFG));
      chk("rst_count2", match_count2, 0);
      rst = 1'b0;

      // Stream before any legal configuration
      run_stream("uncfg", 16'b0100, 16'b0000, 4);
      chk("uncfg_count", match_count, 0);
      chk("uncfg_state", 32'(dut.state), 32'(UNCFG));

      // 1100, overlap
      load(8'h0C, 4'd4, 1'b1);
      chk("t1_state", 32'(dut.state), 32'(FILL));
      chk("t1_load_det", detected, 0);
      run_stream("t1", 16'b11001100, 16'b00010001, 8);
      chk("t1_count", match_count, 2);
      chk("t1_run_state", 32'(dut.state), 32'(RUN));

      // 1010 overlap then non-overlap
      load(8'h0A, 4'd4, 1'b1);
      chk("t2o_count0", match_count, 0);
      run_stream("t2o", 16'b10101010, 16'b00010101, 8);
      chk("t2o_count", match_count, 3);
      load(8'h0A, 4'd4, 1'b0);
      run_stream("t2n", 16'b10101010, 16'b00010001, 8);
      chk("t2n_count", match_count, 2);
      chk("t2n_state", 32'(dut.state), 32'(FILL));

      // Gaps: in_valid low and en low do not break a partial match
      load(8'h0C, 4'd4, 1'b1);
      run_stream("t3", 16'b110, 16'b000, 3);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t3_idle%0d", i), detected, 0);
      end
      en = 1'b0; in_valid = 1'b1; in_sym = 1'b1;
      tick();
      chk("t3_en0_a", detected, 0);
      tick();
      chk("t3_en0_b", detected, 0);
      en = 1'b1; in_valid = 1'b0;
      push_chk("t3_last", 1'b0, 1'b1);
      chk("t3_cfg_err", cfg_err, 0);
      tick();
      chk("t3_pulse_end", detected, 0);
      chk("t3_count", match_count, 1);

      // Illegal lengths are rejected and leave the old config working
      cfg_load = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd0; cfg_overlap = 1'b0;
      in_valid = 1'b1; in_sym = 1'b1;
      tick();
      chk("t4_err0", cfg_err, 1);
      chk("t4_err0_det", detected, 0);
      cfg_len = 4'd9;
      tick();
      chk("t4_err9", cfg_err, 1);
      cfg_load = 1'b0; in_valid = 1'b0;
      tick();
      chk("t4_err_end", cfg_err, 0);
      chk("t4_count_kept", match_count, 1);
      chk("t4_state_kept", 32'(dut.state), 32'(RUN));
      run_stream("t4", 16'b1100, 16'b0001, 4);
      chk("t4_count", match_count, 2);

      // len=1 non-overlap, counter saturation on the CNT_W=2 instance
      en = 1'b0;
      load(8'h01, 4'd1, 1'b0);
      chk("t5_count0", match_count, 0);
      chk("t5_count2_0", match_count2, 0);
      en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         push_chk($sformatf("t5_one%0d", i), 1'b1, 1'b1);
         chk($sformatf("t5_det2_%0d", i), detected2, 1);
         chk($sformatf("t5_cnt_%0d", i), match_count, i);
         chk($sformatf("t5_cnt2_%0d", i), match_count2, (i > 3) ? 3 : i);
      end
      push_chk("t5_zero", 1'b0, 1'b0);
      load(8'h01, 4'd1, 1'b0);
      chk("t5_reload_cnt", match_count, 0);
      chk("t5_reload_cnt2", match_count2, 0);

      // Reset mid-match
      load(8'h0C, 4'd4, 1'b1);
      run_stream("t6", 16'b110, 16'b000, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_det", detected, 0);
      chk("t6_count", match_count, 0);
      chk("t6_cfg_err", cfg_err, 0);
      chk("t6_state", 32'(dut.state), 32'(UNCFG));
      push_chk("t6_after", 1'b0, 1'b0);
      chk("t6_count_after", match_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
